// File: rtl/chan_mux_pkg.sv
// Shared encodings and sizing helpers for the scanning channel multiplexer.
package chan_mux_pkg;

  localparam logic MODE_MAN  = 1'b0;
  localparam logic MODE_SCAN = 1'b1;

  typedef enum logic {
    S_MAN  = 1'b0,
    S_SCAN = 1'b1
  } state_e;

  // Index width for a range of n values, never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/chan_next_find.sv
// Circular search for the next enabled channel strictly after cur.
// Returns cur unchanged when no channel is enabled.
module chan_next_find
  import chan_mux_pkg::*;
#(
  parameter int N  = 8,
  parameter int SW = sel_width(N)
) (
  input  logic [SW-1:0] cur,
  input  logic [N-1:0]  en_mask,
  output logic [SW-1:0] nxt,
  output logic          any_en,
  output logic          wrapped
);

  logic          hi_found;
  logic          lo_found;
  logic [SW-1:0] hi_idx;
  logic [SW-1:0] lo_idx;

  // Lowest enabled index above cur wins; otherwise the search wraps to the lowest enabled index.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (en_mask[i]) begin
        if (!hi_found && (SW'(i) > cur)) begin
          hi_idx   = SW'(i);
          hi_found = 1'b1;
        end
        if (!lo_found) begin
          lo_idx   = SW'(i);
          lo_found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    any_en  = |en_mask;
    wrapped = !hi_found && lo_found;
    if (hi_found) begin
      nxt = hi_idx;
    end else if (lo_found) begin
      nxt = lo_idx;
    end else begin
      nxt = cur;
    end
  end

endmodule

// File: rtl/chan_mux_scan.sv
// N-channel registered multiplexer with manual select and an auto-scan mode
// that dwells DWELL cycles on each enabled channel.
module chan_mux_scan
  import chan_mux_pkg::*;
#(
  parameter  int W     = 8,
  parameter  int N     = 8,
  parameter  int DWELL = 4,
  localparam int SW    = sel_width(N)
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [W*N-1:0] DIN,
  input  logic [SW-1:0]  SEL,
  input  logic           MODE,
  input  logic [N-1:0]   EN_MASK,
  input  logic           HOLD,
  output logic [W-1:0]   Y,
  output logic [SW-1:0]  Y_CH,
  output logic           Y_VLD,
  output logic           WRAP
);

  localparam int CW = sel_width(DWELL);

  state_e        state_q, state_d;
  logic [SW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  y_q, y_d;
  logic [SW-1:0] y_ch_q, y_ch_d;
  logic          y_vld_q, y_vld_d;
  logic          wrap_q, wrap_d;

  logic          sel_ok;
  logic [W-1:0]  sel_data;
  logic          ptr_en;
  logic [W-1:0]  ptr_data;
  logic [SW-1:0] find_cur;
  logic [SW-1:0] find_nxt;
  logic          find_any;
  logic          find_wrapped;

  // In manual mode the search starts from the channel on Y (scan entry);
  // in scan mode it starts from the pointer (dwell expiry or masked-off channel).
  assign find_cur = (state_q == S_SCAN) ? ptr_q : y_ch_q;

  chan_next_find #(.N(N), .SW(SW)) u_find (
    .cur     (find_cur),
    .en_mask (EN_MASK),
    .nxt     (find_nxt),
    .any_en  (find_any),
    .wrapped (find_wrapped)
  );

  // Out-of-range SEL matches no channel, so it reads as not selectable.
  always_comb begin
    sel_ok   = 1'b0;
    sel_data = '0;
    ptr_en   = 1'b0;
    ptr_data = '0;
    for (int i = 0; i < N; i++) begin
      if (SEL == SW'(i)) begin
        sel_ok   = EN_MASK[i];
        sel_data = DIN[i*W +: W];
      end
      if (ptr_q == SW'(i)) begin
        ptr_en   = EN_MASK[i];
        ptr_data = DIN[i*W +: W];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_MAN;
      ptr_q   <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
      y_ch_q  <= '0;
      y_vld_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      y_ch_q  <= y_ch_d;
      y_vld_q <= y_vld_d;
      wrap_q  <= wrap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!HOLD) begin
      state_d = (MODE == MODE_SCAN) ? S_SCAN : S_MAN;
    end
  end

  // Valid semantics: Y_VLD is high for exactly the cycles in which Y/Y_CH carry
  // a fresh sample of an enabled channel; there is no back-pressure, the
  // consumer must take the word in that cycle. Y/Y_CH keep their last value otherwise.
  always_comb begin
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    y_ch_d  = y_ch_q;
    y_vld_d = 1'b0;
    wrap_d  = 1'b0;
    if (!HOLD) begin
      if (state_q == S_MAN) begin
        if (sel_ok) begin
          y_d     = sel_data;
          y_ch_d  = SEL;
          y_vld_d = 1'b1;
        end
        if (MODE == MODE_SCAN) begin
          ptr_d = find_nxt;
          cnt_d = '0;
        end
      end else if (!find_any) begin
        cnt_d = '0;
      end else if (!ptr_en) begin
        ptr_d  = find_nxt;
        cnt_d  = '0;
        wrap_d = find_wrapped;
      end else begin
        y_d     = ptr_data;
        y_ch_d  = ptr_q;
        y_vld_d = 1'b1;
        if (cnt_q == CW'(DWELL - 1)) begin
          ptr_d  = find_nxt;
          cnt_d  = '0;
          wrap_d = find_wrapped;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end
  end

  assign Y     = y_q;
  assign Y_CH  = y_ch_q;
  assign Y_VLD = y_vld_q;
  assign WRAP  = wrap_q;

endmodule

// File: tb/tb_chan_mux_scan.sv
// Randomised scoreboard bench for chan_mux_scan against a cycle-level reference model.
module tb_chan_mux_scan;

  localparam int W     = 12;
  localparam int N     = 6;
  localparam int DWELL = 3;
  localparam int SW    = 3;
  localparam int EW    = W + SW + 2;

  logic           CLK;
  logic           RST;
  logic [W*N-1:0] DIN;
  logic [SW-1:0]  SEL;
  logic           MODE;
  logic [N-1:0]   EN_MASK;
  logic           HOLD;
  logic [W-1:0]   Y;
  logic [SW-1:0]  Y_CH;
  logic           Y_VLD;
  logic           WRAP;

  chan_mux_scan #(.W(W), .N(N), .DWELL(DWELL)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .DIN     (DIN),
    .SEL     (SEL),
    .MODE    (MODE),
    .EN_MASK (EN_MASK),
    .HOLD    (HOLD),
    .Y       (Y),
    .Y_CH    (Y_CH),
    .Y_VLD   (Y_VLD),
    .WRAP    (WRAP)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int tests_run = 0;
  int tests_failed = 0;

  // ---------------- reference model ----------------
  bit           m_scan;
  int           m_ptr, m_cnt, m_ych;
  logic [W-1:0] m_y;
  bit           m_vld, m_wrap;

  function automatic bit is_en(input logic [N-1:0] m, input int c);
    logic [N-1:0] t;
    t = m >> c;
    return t[0];
  endfunction

  function automatic int next_en(input int cur, input logic [N-1:0] m);
    for (int s = 1; s <= N; s++) begin
      if (is_en(m, (cur + s) % N)) return (cur + s) % N;
    end
    return cur;
  endfunction

  function automatic logic [W-1:0] chan(input logic [W*N-1:0] d, input int c);
    logic [W*N-1:0] t;
    t = d >> (c * W);
    return t[W-1:0];
  endfunction

  task automatic model_edge(input bit rst, input bit hold, input bit mode, input int sel,
                            input logic [N-1:0] mask, input logic [W*N-1:0] d);
    int old;
    if (rst) begin
      m_scan = 0; m_ptr = 0; m_cnt = 0; m_y = '0; m_ych = 0; m_vld = 0; m_wrap = 0;
    end else if (hold) begin
      m_vld = 0; m_wrap = 0;
    end else begin
      m_vld = 0; m_wrap = 0;
      if (!m_scan) begin
        if (mode) begin
          m_ptr = next_en(m_ych, mask);
          m_cnt = 0;
        end
        if (sel < N && is_en(mask, sel)) begin
          m_y = chan(d, sel); m_ych = sel; m_vld = 1;
        end
      end else if (mask == '0) begin
        m_cnt = 0;
      end else if (!is_en(mask, m_ptr)) begin
        old = m_ptr;
        m_ptr = next_en(m_ptr, mask);
        m_cnt = 0;
        m_wrap = (m_ptr <= old);
      end else begin
        m_y = chan(d, m_ptr); m_ych = m_ptr; m_vld = 1;
        m_cnt++;
        if (m_cnt == DWELL) begin
          old = m_ptr;
          m_ptr = next_en(m_ptr, mask);
          m_cnt = 0;
          m_wrap = (m_ptr <= old);
        end
      end
      m_scan = mode;
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit rst, input bit hold, input bit mode, input int sel,
                      input logic [N-1:0] mask);
    logic [W*N-1:0] d;
    @(negedge CLK);
    for (int c = 0; c < N; c++) d[c*W +: W] = W'($urandom);
    RST = rst; HOLD = hold; MODE = mode; SEL = SW'(sel); EN_MASK = mask; DIN = d;
    model_edge(rst, hold, mode, sel, mask, d);
    exp_q.push_back({m_y, SW'(m_ych), m_vld, m_wrap});
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [EW-1:0] e, a;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {Y, Y_CH, Y_VLD, WRAP};
        tests_run++;
        if (a !== e) begin
          tests_failed++;
          $display("FAIL out_t%0t: got y=%h ch=%0d vld=%0d wrap=%0d, required y=%h ch=%0d vld=%0d wrap=%0d",
                   $time, a[EW-1 -: W], a[SW+1:2], a[1], a[0],
                   e[EW-1 -: W], e[SW+1:2], e[1], e[0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit mode;
    logic [N-1:0] mask;
    int k;
    RST = 1'b1; HOLD = 1'b0; MODE = 1'b0; SEL = '0; EN_MASK = '1; DIN = '0;

    // reset and manual selection
    step(1, 0, 0, 3, 6'h3F);
    step(1, 0, 0, 3, 6'h3F);
    step(0, 0, 0, 3, 6'h3F);
    step(0, 0, 0, 5, 6'h3F);
    step(0, 0, 0, 3, 6'h37);
    step(0, 0, 0, 3, 6'h37);
    step(0, 0, 0, 3, 6'h3F);
    step(0, 0, 0, 6, 6'h3F);
    step(0, 0, 0, 7, 6'h3F);
    // scan over a sparse mask, then single channel, empty mask, restore
    for (int i = 0; i < 14; i++) step(0, 0, 1, 0, 6'b100101);
    for (int i = 0; i < 8; i++)  step(0, 0, 1, 0, 6'b010000);
    for (int i = 0; i < 4; i++)  step(0, 0, 1, 0, 6'b000000);
    for (int i = 0; i < 5; i++)  step(0, 0, 1, 0, 6'b000001);
    // hold mid-dwell, then reset during hold
    for (int i = 0; i < 4; i++)  step(0, 0, 1, 0, 6'b000110);
    for (int i = 0; i < 5; i++)  step(0, 1, 0, 0, 6'b000110);
    for (int i = 0; i < 3; i++)  step(0, 0, 1, 0, 6'b000110);
    step(0, 1, 1, 0, 6'b000110);
    step(1, 1, 1, 0, 6'b000110);
    step(0, 0, 0, 1, 6'b000110);

    // randomised run
    mode = 1'b0;
    mask = '1;
    for (int i = 0; i < 2000; i++) begin
      if ((i >= 1500 && i < 1560) || $urandom_range(0, 15) == 0) mode = ~mode;
      if ($urandom_range(0, 7) == 0) begin
        k = $urandom_range(0, 3);
        case (k)
          0: mask = '0;
          1: mask = N'(1) << $urandom_range(0, N - 1);
          2: mask = '1;
          default: mask = N'($urandom);
        endcase
      end
      step($urandom_range(0, 199) == 0, $urandom_range(0, 9) == 0, mode,
           $urandom_range(0, 7), mask);
    end

    repeat (2) @(negedge CLK);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: got %0d pending, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/chan_mux_scan.md
Name: chan_mux_scan

Overview:
Parametrised successor to the team's combinational 8:1 byte multiplexer. Selects one of N channels of W-bit data into a registered output. Supports manual selection by SEL, or an auto-scan mode that rotates through enabled channels with a programmable dwell time. Sits between parallel sample sources and a single downstream consumer, such as a display or UART packer, and qualifies every output word with a valid flag.

Parameters:
W, 8, data width per channel (>=1)
N, 8, channel count (2..64)
DWELL, 4, cycles spent on each channel in scan mode (>=1)
SW, $clog2(N), derived select width (localparam, not overridable)

Ports:
CLK  in  1  clock; all logic is rising-edge
RST  in  1  synchronous, active-high reset
DIN  in  W*N  packed channels; channel i is DIN[i*W +: W]
SEL  in  SW  manual channel select
MODE  in  1  0 = manual, 1 = scan
EN_MASK  in  N  per-channel enable; bit i=1 means channel i is selectable
HOLD  in  1  freeze request
Y  out  W  selected data (registered)
Y_CH  out  SW  index of the channel in Y
Y_VLD  out  1  Y/Y_CH hold a valid, enabled channel this cycle
WRAP  out  1  one-cycle pulse when the scan pointer wraps to a lower index

Behaviour:
- Reset (RST=1 at a clock edge):
  - Y=0, Y_CH=0, Y_VLD=0, WRAP=0.
  - Scan pointer=0, dwell counter=0, state=S_MAN.
  - RST has priority over HOLD and every other input.
- FSM states: S_MAN and S_SCAN.
  - Next state follows MODE, sampled every non-HOLD cycle.
  - Entering S_SCAN: pointer loads the next enabled channel strictly after the current Y_CH (circular search); counter clears.
  - Entering S_MAN: takes effect on the following cycle using SEL.
- S_MAN, latency 1:
  - If SEL<N and EN_MASK[SEL]=1: Y<=DIN[SEL], Y_CH<=SEL, Y_VLD<=1.
  - Otherwise (SEL>=N for non-power-of-2 N, or channel masked): Y and Y_CH hold, Y_VLD<=0.
- S_SCAN:
  - Every cycle: Y<=DIN[ptr], Y_CH<=ptr, Y_VLD<=1. Data is sampled each cycle, not latched once per dwell.
  - Counter runs 0..DWELL-1. At DWELL-1 the pointer advances to the next enabled channel (circular, N-1 wraps to 0) and the counter clears.
  - WRAP<=1 in the cycle the new pointer is <= the old pointer; WRAP=0 otherwise.
  - DWELL=1: pointer advances every cycle.
  - Current channel masked off mid-dwell: advance on the next edge, counter clears.
  - Exactly one channel enabled: pointer stays on it. At each dwell expiry WRAP pulses, because new = old.
  - EN_MASK all zero: Y, Y_CH, pointer hold; counter held at 0; Y_VLD=0; WRAP=0. Scan resumes from the next enabled channel after ptr once any bit sets.
- HOLD=1:
  - All state registers freeze: Y, Y_CH, pointer, counter, FSM state.
  - Y_VLD and WRAP are forced to 0.
  - A MODE change during HOLD is applied on the first cycle after HOLD drops.
- Simultaneous events:
  - Mask change and dwell expiry in the same cycle: the search uses the new mask.
  - MODE toggling every cycle is legal; each entry to S_SCAN restarts the dwell.

Decomposition:
- Shared package chan_mux_pkg holds:
  - MODE_MAN and MODE_SCAN encodings.
  - State encodings S_MAN and S_SCAN.
  - A constant function for SW.
- One sub-module, chan_next_find: purely combinational. Given N, the current index and EN_MASK, it returns the next enabled index after the current one (circular), an any_en flag and a wrapped flag.
- It is instantiated once and shared by scan advance and scan entry.

Test Plan:
- Reset/manual: RST 2 cycles, MODE=0, EN_MASK=8'hFF, DIN channel k = 8'h10+k, SEL=3 -> after reset Y=0, Y_VLD=0. Then one cycle later Y=8'h13, Y_CH=3, Y_VLD=1. SEL=5 gives Y=8'h15 on the next edge.
- Masked manual: EN_MASK=8'hF7, SEL=3 -> Y holds its previous value, Y_VLD=0. EN_MASK[3] set gives Y=8'h13, Y_VLD=1 one cycle later.
- Scan sequence: MODE=1, DWELL=4, EN_MASK=8'b1010_0101 -> Y_CH walks 0,2,5,7,0 with each index held 4 cycles. WRAP pulses once on 7->0.
- Scan edge cases:
  - Single channel, EN_MASK=8'h10 -> Y_CH stays 4, WRAP pulses every 4 cycles.
  - EN_MASK=0 -> Y_VLD=0 and Y_CH frozen. Restoring 8'h01 resumes on channel 0.
- HOLD/reset mid-scan: HOLD=1 for 5 cycles at counter=2 on channel 2 -> Y_VLD=0 and outputs frozen, then 2 more cycles on channel 2 after HOLD drops. RST asserted during HOLD -> all outputs 0, state S_MAN.
- Randomised check: random DIN/SEL/MODE/EN_MASK for 2000 cycles with N=6, W=12 -> matches the reference model each cycle. SEL=6 or 7 always gives Y_VLD=0 in manual mode.
